// File: rtl/mem_dma_if.sv
// Control, status and memory-port bundle for mem_dma.
// The slave modport is the DMA engine; master is its controller/memory.
interface mem_dma_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
);
    logic              i_start;
    logic              i_mode;
    logic [ADDR_W-1:0] i_src;
    logic [ADDR_W-1:0] i_dst;
    logic [ADDR_W:0]   i_len;
    logic [DATA_W-1:0] i_fill;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W:0]   o_count;
    logic [1:0]        o_mem_op;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_data;
    logic [DATA_W-1:0] i_mem_data;

    modport slave (
        input  i_start, i_mode, i_src, i_dst, i_len, i_fill, i_mem_data,
        output o_busy, o_done, o_count, o_mem_op, o_mem_addr, o_mem_data
    );

    modport master (
        output i_start, i_mode, i_src, i_dst, i_len, i_fill, i_mem_data,
        input  o_busy, o_done, o_count, o_mem_op, o_mem_addr, o_mem_data
    );
endinterface

// File: rtl/mem_dma.sv
// Single-port memory DMA: word copy (read-k then write-k) or pattern fill.
// Memory-port outputs are decoded from the state, so reset silences them at once.
module mem_dma #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic     i_clk,
    input  logic     i_rst,
    mem_dma_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              mode_q,  mode_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [ADDR_W:0]   len_q,   len_d;
    logic [DATA_W-1:0] fill_q,  fill_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] word_idx;

    assign count_inc = count_q + (ADDR_W+1)'(1);
    // Inside RD/WR count < len <= 2^ADDR_W, so the low bits are the full index.
    assign word_idx  = count_q[ADDR_W-1:0];

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    mode_d  = bus.i_mode;
                    src_d   = bus.i_src;
                    dst_d   = bus.i_dst;
                    len_d   = bus.i_len;
                    fill_d  = bus.i_fill;
                    count_d = '0;
                    if (bus.i_len == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.i_mode) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                count_d = count_inc;
                if (count_inc == len_q) begin
                    state_d = ST_DONE;
                end else if (mode_q) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_busy     = 1'b0;
        bus.o_done     = 1'b0;
        bus.o_mem_op   = OP_NONE;
        bus.o_mem_addr = '0;
        bus.o_mem_data = '0;
        case (state_q)
            ST_RD: begin
                bus.o_busy     = 1'b1;
                bus.o_mem_op   = OP_READ;
                bus.o_mem_addr = src_q + word_idx;
            end
            ST_WR: begin
                bus.o_busy     = 1'b1;
                bus.o_mem_op   = OP_WRITE;
                bus.o_mem_addr = dst_q + word_idx;
                // Copy data is the read issued in the preceding RD cycle.
                bus.o_mem_data = mode_q ? fill_q : bus.i_mem_data;
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
            end
            default: begin
                bus.o_busy = 1'b0;
            end
        endcase
    end

    assign bus.o_count = count_q;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a vector table of transfers against a word-memory
// model, plus hand sequences for reset behaviour and preserved memory contents.
module tb_mem_dma;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef struct {
        string       name;
        bit          mode;
        logic [12:0] src;
        logic [12:0] dst;
        logic [13:0] len;
        logic [63:0] fill;
        int          exp_busy;
        bit          restart;
    } vec_t;

    logic clk;
    logic rst;
    logic preload;

    mem_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_word(int a);
        return {32'hA5A5_0000 + 32'(a), 32'(a) ^ 32'h1234_5678};
    endfunction

    // Memory model: registered read data, valid the cycle after a READ.
    logic [63:0] mem [0:DEPTH-1];
    logic [63:0] rd_data;
    logic [63:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (bus.o_mem_op == OP_WRITE) begin
            mem[bus.o_mem_addr] <= bus.o_mem_data;
        end
        if (bus.o_mem_op == OP_READ) rd_data <= mem[bus.o_mem_addr];
    end

    assign bus.i_mem_data = rd_data;

    // Monitor samples on the falling edge, away from the active edge.
    int          cyc, busy_tot, done_tot, done_cyc, bad_tot, n_ops;
    logic [1:0]  log_op   [0:1023];
    logic [12:0] log_addr [0:1023];
    logic [63:0] log_data [0:1023];

    always @(negedge clk) begin
        if (preload) begin
            cyc      <= 0;
            busy_tot <= 0;
            done_tot <= 0;
            done_cyc <= 0;
            bad_tot  <= 0;
            n_ops    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.o_busy) busy_tot <= busy_tot + 1;
            if (bus.o_done) begin
                done_tot <= done_tot + 1;
                done_cyc <= cyc + 1;
            end
            if (bus.o_mem_op != OP_NONE && n_ops < 1024) begin
                log_op[n_ops]   <= bus.o_mem_op;
                log_addr[n_ops] <= bus.o_mem_addr;
                log_data[n_ops] <= bus.o_mem_data;
                n_ops           <= n_ops + 1;
            end
            if ((bus.o_mem_op == OP_NONE && (bus.o_mem_addr != '0 || bus.o_mem_data != '0)) ||
                (bus.o_busy != (bus.o_mem_op != OP_NONE)) ||
                (bus.o_busy && bus.o_done) || bus.o_mem_op == 2'd3)
                bad_tot <= bad_tot + 1;
        end
    end

    int errors;
    int checks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        int          b_ops, b_busy, b_done, b_cyc, b_bad, t, mism, n_exp;
        logic [1:0]  e_op   [$];
        logic [12:0] e_addr [$];
        logic [63:0] e_data [$];
        logic [12:0] a_s, a_d;
        logic [63:0] d;
        b_ops  = n_ops;
        b_busy = busy_tot;
        b_done = done_tot;
        b_cyc  = cyc;
        b_bad  = bad_tot;
        // Reference: strict ascending read-k, write-k on the shadow memory.
        for (int i = 0; i < int'(v.len); i++) begin
            a_s = v.src + 13'(i);
            a_d = v.dst + 13'(i);
            d   = v.mode ? v.fill : ref_mem[a_s];
            if (!v.mode) begin
                e_op.push_back(OP_READ);
                e_addr.push_back(a_s);
                e_data.push_back(64'h0);
            end
            e_op.push_back(OP_WRITE);
            e_addr.push_back(a_d);
            e_data.push_back(d);
            ref_mem[a_d] = d;
        end
        bus.i_mode  = v.mode;
        bus.i_src   = v.src;
        bus.i_dst   = v.dst;
        bus.i_len   = v.len;
        bus.i_fill  = v.fill;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_mode  = ~v.mode;
        bus.i_src   = ~v.src;
        bus.i_dst   = v.src;
        bus.i_len   = 14'd7;
        bus.i_fill  = ~v.fill;
        if (v.restart) begin
            step();
            step();
            bus.i_start = 1'b1;
            step();
            bus.i_start = 1'b0;
        end
        t = 0;
        while (done_tot == b_done && t < 100) begin
            step();
            t++;
        end
        check({v.name, "_done_seen"}, 64'(done_tot != b_done), 64'd1);
        check({v.name, "_done_latency"}, 64'(done_cyc - b_cyc), 64'(v.exp_busy + 1));
        repeat (3) step();
        check({v.name, "_done_pulses"}, 64'(done_tot - b_done), 64'd1);
        check({v.name, "_busy_cycles"}, 64'(busy_tot - b_busy), 64'(v.exp_busy));
        check({v.name, "_count_held"}, 64'(bus.o_count), 64'(v.len));
        check({v.name, "_port_rules"}, 64'(bad_tot - b_bad), 64'd0);
        n_exp = e_op.size();
        check({v.name, "_op_count"}, 64'(n_ops - b_ops), 64'(n_exp));
        mism = 0;
        for (int i = 0; i < n_exp && (b_ops + i) < n_ops; i++) begin
            if (log_op[b_ops+i] !== e_op[i] || log_addr[b_ops+i] !== e_addr[i] ||
                (e_op[i] == OP_WRITE && log_data[b_ops+i] !== e_data[i])) begin
                if (mism == 0)
                    $display("FAIL %s_op_seq[%0d]: got op=%0d addr=%0h data=%0h expected op=%0d addr=%0h data=%0h",
                             v.name, i, log_op[b_ops+i], log_addr[b_ops+i], log_data[b_ops+i],
                             e_op[i], e_addr[i], e_data[i]);
                mism++;
            end
        end
        checks++;
        if (mism != 0) errors++;
        mism = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            a_d = v.dst + 13'(i);
            if (mem[a_d] !== ref_mem[a_d]) mism++;
        end
        check({v.name, "_mem_words_bad"}, 64'(mism), 64'd0);
    endtask

    vec_t vecs [7];
    int   b_done_r, b_ops_r, t_r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        preload = 1'b1;
        bus.i_start = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_src   = '0;
        bus.i_dst   = '0;
        bus.i_len   = '0;
        bus.i_fill  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        vecs[0] = '{"copy4",      1'b0, 13'h0010, 13'h0100, 14'd4, 64'h0,                 8, 1'b0};
        vecs[1] = '{"fill_wrap",  1'b1, 13'h0000, 13'h1FFE, 14'd4, 64'hDEAD_BEEF,         4, 1'b0};
        vecs[2] = '{"copy_len0",  1'b0, 13'h0030, 13'h0040, 14'd0, 64'h0,                 0, 1'b0};
        vecs[3] = '{"overlap",    1'b0, 13'h0020, 13'h0021, 14'd3, 64'h0,                 6, 1'b1};
        vecs[4] = '{"fill1",      1'b1, 13'h0000, 13'h0050, 14'd1, 64'h0123_4567_89AB_CDEF, 1, 1'b0};
        vecs[5] = '{"copy_srcwrap", 1'b0, 13'h1FFE, 13'h0600, 14'd3, 64'h0,               6, 1'b0};
        vecs[6] = '{"fill_len0",  1'b1, 13'h0000, 13'h0700, 14'd0, 64'hFFFF,              0, 1'b0};

        // Reset forces outputs before any clock edge.
        #2;
        check("rst_busy",  64'(bus.o_busy),     64'd0);
        check("rst_done",  64'(bus.o_done),     64'd0);
        check("rst_count", 64'(bus.o_count),    64'd0);
        check("rst_op",    64'(bus.o_mem_op),   64'(OP_NONE));
        check("rst_addr",  64'(bus.o_mem_addr), 64'd0);
        check("rst_data",  bus.o_mem_data,      64'd0);
        step();
        preload = 1'b0;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        for (int i = 0; i < 4; i++)
            check($sformatf("copy4_dst_word%0d", i), mem[13'h100 + 13'(i)], init_word(16 + i));
        for (int i = 0; i < 3; i++)
            check($sformatf("overlap_word%0d", i), mem[13'h21 + 13'(i)], init_word(32'h20));
        check("fill_wrap_1fff", mem[13'h1FFF], 64'hDEAD_BEEF);
        check("fill_wrap_0001", mem[13'h0001], 64'hDEAD_BEEF);

        // Asynchronous reset during the second WR of a len=4 copy.
        b_done_r    = done_tot;
        bus.i_mode  = 1'b0;
        bus.i_src   = 13'h0010;
        bus.i_dst   = 13'h0400;
        bus.i_len   = 14'd4;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        t_r = 0;
        while (!(bus.o_mem_op == OP_WRITE && bus.o_count == 14'd1) && t_r < 20) begin
            step();
            t_r++;
        end
        check("rstmid_wr2_op",    64'(bus.o_mem_op),   64'(OP_WRITE));
        check("rstmid_wr2_addr",  64'(bus.o_mem_addr), 64'h401);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_op",    64'(bus.o_mem_op),   64'(OP_NONE));
        check("rstmid_busy",  64'(bus.o_busy),     64'd0);
        check("rstmid_count", 64'(bus.o_count),    64'd0);
        check("rstmid_done",  64'(bus.o_done),     64'd0);
        check("rstmid_addr",  64'(bus.o_mem_addr), 64'd0);
        b_ops_r = n_ops;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("rstmid_no_done", 64'(done_tot - b_done_r), 64'd0);
        check("rstmid_no_ops",  64'(n_ops - b_ops_r),     64'd0);
        check("rstmid_word0_kept",   mem[13'h400], init_word(16));
        check("rstmid_word1_untouched", mem[13'h401], init_word(32'h401));
        ref_mem[13'h400] = init_word(16);

        run_xfer('{"post_rst", 1'b0, 13'h0010, 13'h0400, 14'd4, 64'h0, 8, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory word width.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  request a transfer, sampled on rising edge.
REQ-006 SHALL have port i_mode  input  1  transfer mode: 0 = copy, 1 = fill.
REQ-007 SHALL have port i_src  input  ADDR_W  copy source base address.
REQ-008 SHALL have port i_dst  input  ADDR_W  destination base address.
REQ-009 SHALL have port i_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-010 SHALL have port i_fill  input  DATA_W  fill pattern.
REQ-011 SHALL have port o_busy  output  1  transfer in progress.
REQ-012 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port o_count  output  ADDR_W+1  words written so far in the current or last transfer.
REQ-014 SHALL have port o_mem_op  output  2  memory port op: 0 NONE, 1 READ, 2 WRITE.
REQ-015 SHALL have port o_mem_addr  output  ADDR_W  memory port address.
REQ-016 SHALL have port o_mem_data  output  DATA_W  memory port write data.
REQ-017 SHALL have port i_mem_data  input  DATA_W  memory port read data, valid the cycle after a READ is issued.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-019 SHALL accept i_start only in IDLE and ignore it in every other state.
REQ-020 SHALL latch i_mode, i_src, i_dst, i_len and i_fill on acceptance; input changes during a transfer have no effect.
REQ-021 On acceptance, SHALL clear o_count and go to DONE if i_len=0, else to RD (copy) or WR (fill).
REQ-022 In RD, SHALL drive o_mem_op=READ and o_mem_addr=src+k, with k = o_count, then go to WR.
REQ-023 In WR, SHALL drive o_mem_op=WRITE and o_mem_addr=dst+k; o_mem_data = i_mem_data in copy mode and the latched fill value in fill mode.
REQ-024 On leaving WR, SHALL increment o_count, go to DONE if o_count+1 equals the latched len, else go to RD (copy) or stay in WR (fill).
REQ-025 Throughput SHALL be 2 cycles per word in copy mode and 1 cycle per word in fill mode.
REQ-026 SHALL compute address sums modulo 2^ADDR_W, so addresses wrap from 8191 to 0.
REQ-027 SHALL process words in ascending order with no overlap protection; the result of overlapping regions follows from strict read-k, write-k ordering.
REQ-028 In IDLE and DONE, SHALL drive o_mem_op=NONE with o_mem_addr=0 and o_mem_data=0.
REQ-029 SHALL assert o_busy exactly in RD and WR.
REQ-030 SHALL assert o_done exactly in DONE, which lasts one cycle and returns to IDLE.
REQ-031 SHALL hold o_count after completion until the next accepted start.
REQ-032 Start-to-first-memory-op latency SHALL be 1 cycle: the op is on the port in the cycle after the start edge.

Reset
REQ-033 While i_rst is high, SHALL force state IDLE, o_busy=0, o_done=0, o_count=0 and o_mem_op=NONE, with o_mem_addr and o_mem_data at 0, regardless of clock.
REQ-034 Reset mid-transfer SHALL abort without a done pulse; words already written remain written and no further ops are issued.

Verification
REQ-035 Copy: memory[0x10..0x13]=A,B,C,D, start mode 0 with src=0x10, dst=0x100, len=4 -> 8 busy cycles, alternating READ/WRITE, memory[0x100..0x103]=A,B,C,D, one o_done pulse, o_count=4.
REQ-036 Fill with wrap: start mode 1 with dst=0x1FFE, len=4, fill=0xDEADBEEF -> writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001 on 4 consecutive cycles, then o_done.
REQ-037 Zero length: start with len=0 -> no READ or WRITE issued, o_busy stays 0, o_done pulses in the cycle after start, o_count=0.
REQ-038 Overlap and ignored start: copy src=0x20, dst=0x21, len=3 with memory[0x20]=X, with i_start re-asserted mid-transfer -> memory[0x21..0x23]=X, second start ignored, single o_done.
REQ-039 Reset mid-operation: assert i_rst asynchronously during the second WR of a len=4 copy -> o_mem_op=NONE immediately, o_busy=0, o_count=0, no o_done, and the next start operates normally.
